// File: rtl/fetch_sequencer.sv
// Fetch-stage control: arbitrates freeze, branch, jump, halt and load-use requests
// into PC hold/redirect and pipeline squash controls, deferring redirects seen during a freeze.
module fetch_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_busy,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              load_use_hazard,
  output logic              stall_flush,
  output logic              PC_Src,
  output logic [ADDR_W-1:0] PC_jump,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        fsm_state,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, HALT = 2'd3} state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_e              state_q, state_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]   pend_target_q, pend_target_d;
  logic [3:0]          flush_cnt_q, flush_cnt_d;
  logic [15:0]         stall_cycles_q, stall_cycles_d;

  logic                sf, src, flush, bub;
  logic [ADDR_W-1:0]   pcj;
  logic                cap_en;
  logic [ADDR_W-1:0]   cap_target;

  // A branch always overrides a queued target; a jump only fills an empty slot.
  always_comb begin
    cap_en     = branch_taken || (jump_valid && !pend_valid_q);
    cap_target = branch_taken ? branch_target : jump_target;
  end

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    flush_cnt_d   = flush_cnt_q;
    sf            = 1'b0;
    src           = 1'b0;
    flush         = 1'b0;
    bub           = 1'b0;
    pcj           = '0;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          sf      = 1'b1;
          state_d = STALL;
          if (cap_en) begin
            pend_valid_d  = 1'b1;
            pend_target_d = cap_target;
          end
        end else if (pend_valid_q || branch_taken || jump_valid) begin
          src          = 1'b1;
          flush        = 1'b1;
          bub          = pend_valid_q || branch_taken;
          pcj          = pend_valid_q ? pend_target_q :
                         (branch_taken ? branch_target : jump_target);
          pend_valid_d = 1'b0;
          state_d      = FLUSH;
          flush_cnt_d  = FLUSH_INIT;
        end else if (halt_req) begin
          sf      = 1'b1;
          state_d = HALT;
        end else if (load_use_hazard) begin
          sf  = 1'b1;
          bub = 1'b1;
        end
      end
      STALL: begin
        sf = 1'b1;
        if (cap_en) begin
          pend_valid_d  = 1'b1;
          pend_target_d = cap_target;
        end
        if (!mem_busy) state_d = RUN;
      end
      FLUSH: begin
        // Requests here come from wrong-path instructions and are dropped.
        flush = 1'b1;
        if (mem_busy) begin
          sf = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_cnt_q == 4'd1) state_d = RUN;
        end
      end
      HALT: begin
        sf = 1'b1;
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    stall_cycles_d = (sf && stall_cycles_q != 16'hFFFF) ? stall_cycles_q + 16'd1 : stall_cycles_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      pend_valid_q   <= 1'b0;
      pend_target_q  <= '0;
      flush_cnt_q    <= 4'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      pend_valid_q   <= pend_valid_d;
      pend_target_q  <= pend_target_d;
      flush_cnt_q    <= flush_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_flush  = sf & ~reset;
  assign PC_Src       = src & ~reset;
  assign PC_jump      = reset ? '0 : pcj;
  assign if_id_flush  = flush & ~reset;
  assign id_ex_bubble = bub & ~reset;
  assign fsm_state    = state_q;
  assign stall_cycles = stall_cycles_q;

  assert property (@(posedge clk) disable iff (reset) !(PC_Src && stall_flush));

endmodule
